handshake_constant_check: RTL and testbench
===========================================

# handshake_constant_check

Dataflow sink-side companion to the constant generator. It accepts data tokens on an elastic input channel and compares each token against a compile-time constant. For every consumed token it emits one dataless control token carrying a match flag, and it keeps a saturating mismatch counter and a sticky error flag. It sits at the consuming end of a constant-producing edge in the handshake netlist. It turns a data stream back into a control stream and checks that stream in-line.

## Interface
- DATA_WIDTH, 32: width of the `ins` data token.
- CONST_VALUE, 32'h00000FF4: expected token value. It is truncated or zero-extended to DATA_WIDTH.
- CNT_WIDTH, 16: width of `mismatch_count`.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to clk.
- ins  input  DATA_WIDTH  data token.
- ins_valid  input  1  `ins` carries a token.
- ins_ready  output  1  block can accept a token this cycle.
- outs_valid  output  1  control token available.
- outs_ready  input  1  downstream accepts the control token.
- match  output  1  qualifies the head control token: 1 means the source data equalled CONST_VALUE. Driven 0 when `outs_valid`=0.
- mismatch_count  output  CNT_WIDTH  number of accepted non-matching tokens, saturating.
- error  output  1  sticky; set by the first mismatch.

## Operation
Storage:
- 2-entry FIFO of 1-bit match results.
- Entry registers `m0`/`m1`, a 2-bit occupancy `count` (0..2), and a head pointer `rd_ptr` (1 bit).
- Write pointer is `rd_ptr ^ count[0]`, i.e. the slot after the last occupied entry (slot `rd_ptr` when count=0, the other slot when count=1).

Handshake events:
- Push when `ins_valid && ins_ready`. The entry at the write pointer is written with `(ins == CONST_VALUE)`, compared over the full DATA_WIDTH.
- Pop when `outs_valid && outs_ready`. `rd_ptr` toggles.
- `count` next = count + push − pop. A push and a pop in the same cycle leave `count` unchanged.

Outputs:
- `ins_ready` = (count != 2). It depends only on registered state; there is no combinational path from `outs_ready`.
- `outs_valid` = (count != 0). `match` = head entry when `outs_valid`, else 0.

Checking:
- On a push with a mismatch, `mismatch_count` increments unless it is already all-ones (saturates, no wrap).
- On a push with a mismatch, `error` is set. `error` clears only on reset.

Reset (rst=0, asynchronous):
- count=0, rd_ptr=0, m0=m1=0, mismatch_count=0, error=0.
- Resulting outputs: ins_ready=1, outs_valid=0, match=0.
- Reset mid-transfer discards buffered tokens. No control token is emitted for them and no counter update happens on the reset edge.

Protocol assumptions:
- Upstream keeps `ins` stable while `ins_valid`=1 and `ins_ready`=0. The block does not check this.
- `outs_valid` never drops without a pop.

## Timing
- Latency: a token accepted on edge N makes `outs_valid`=1 with the corresponding `match` after edge N (cycle N+1). There is no same-cycle bypass.
- Throughput: one token per cycle sustained when `outs_ready`=1 continuously.
- Full (count=2): `ins_ready`=0. A pop in that cycle does not enable a same-cycle push; `ins_ready` returns to 1 on the next cycle.
- Empty (count=0): a pop is impossible. A push in that cycle yields count=1.
- count=1 with push and pop in the same cycle: count stays 1. The head advances to the newly written entry, so `match` reflects the new token next cycle.
- `mismatch_count` and `error` update on the push edge, visible the next cycle, concurrently with `outs_valid` for that token.
- Pointer wrap: `rd_ptr` toggles 0→1→0, with no bubble at the wrap.

## Test plan
- Reset, then tokens 0xFF4, 0x123, 0xFF4 with `outs_ready`=1 held → control tokens on consecutive cycles starting one cycle after the first accept, `match` = 1, 0, 1; `mismatch_count`=1, `error`=1 after the second token.
- `outs_ready`=0, drive four tokens of 0xFF4 → two accepted, `ins_ready`=0 from the cycle after the second accept. Raise `outs_ready` → four control tokens total, no loss or duplication, `match`=1 each.
- Random `ins_valid` and `outs_ready` over 1000 tokens, ~25% non-matching → match sequence equals a scoreboard model, `mismatch_count` equals the mismatch tally.
- CNT_WIDTH=4, 20 non-matching tokens → `mismatch_count` reaches 0xF and holds; `error`=1.
- Assert rst low mid-stream with count=2 and `error`=1 → immediately outs_valid=0, ins_ready=1, mismatch_count=0, error=0; after release, the first new token 0xFF4 appears with `match`=1 one cycle after its accept.
- Steady state with count=1 and push and pop every cycle, alternating 0xFF4 and 0x0 → count stays 1 and `match` toggles 1, 0, 1, 0 in order.

Source files
------------

// File: rtl/handshake_constant_check.sv
// -----------------------------------------------------------------------------
// handshake_constant_check
//
// Sink-side checker for a constant-producing handshake edge. Each data token
// accepted on the elastic input is compared against CONST_VALUE. The 1-bit
// comparison result is buffered in a 2-entry FIFO and emitted as a dataless
// control token qualified by `match`. A saturating mismatch counter and a
// sticky error flag summarise the stream since the last reset.
//
// Parameters
//   DATA_WIDTH   width of the input data token
//   CONST_VALUE  expected token value, truncated/zero-extended to DATA_WIDTH
//   CNT_WIDTH    width of the saturating mismatch counter
//
// Ports
//   clk             in   clock, all state updates on rising edge
//   rst             in   asynchronous active-low reset
//   ins             in   data token
//   ins_valid       in   ins carries a token
//   ins_ready       out  block can accept a token this cycle
//   outs_valid      out  control token available
//   outs_ready      in   downstream accepts the control token
//   match           out  head token equalled CONST_VALUE (0 when no token)
//   mismatch_count  out  accepted non-matching tokens, saturating
//   error           out  sticky, set by the first mismatch
// -----------------------------------------------------------------------------
module handshake_constant_check #(
    parameter int DATA_WIDTH  = 32,
    parameter     CONST_VALUE = 32'h0000_0FF4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  match,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  error
);

    localparam logic [DATA_WIDTH-1:0] CONST_D = DATA_WIDTH'(CONST_VALUE);

    // Result FIFO state
    logic       m0;
    logic       m1;
    logic [1:0] count;
    logic       rd_ptr;

    logic       wr_ptr;
    logic       push;
    logic       pop;
    logic       is_match;
    logic       head;

    // Slot after the last occupied entry: rd_ptr when empty, the other slot
    // when one entry is held. Never used when full because push is blocked.
    assign wr_ptr   = rd_ptr ^ count[0];

    assign is_match = (ins == CONST_D);
    assign head     = rd_ptr ? m1 : m0;

    // Ready/valid are pure decodes of registered occupancy, so there is no
    // combinational path from outs_ready to ins_ready. A pop while full frees
    // a slot only from the following cycle.
    assign ins_ready  = (count != 2'd2);
    assign outs_valid = (count != 2'd0);
    assign match      = outs_valid ? head : 1'b0;

    assign push = ins_valid  && ins_ready;
    assign pop  = outs_valid && outs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0             <= 1'b0;
            m1             <= 1'b0;
            count          <= 2'd0;
            rd_ptr         <= 1'b0;
            mismatch_count <= '0;
            error          <= 1'b0;
        end else begin
            if (push) begin
                if (wr_ptr) begin
                    m1 <= is_match;
                end else begin
                    m0 <= is_match;
                end
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (push && !is_match) begin
                error <= 1'b1;
                if (mismatch_count != {CNT_WIDTH{1'b1}}) begin
                    mismatch_count <= mismatch_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_handshake_constant_check.sv
// -----------------------------------------------------------------------------
// Directed bench for handshake_constant_check. A queue of expected match bits
// is filled on every accepted token and drained on every emitted control
// token; directed checks cover reset, back-pressure, steady state, reset
// mid-stream and counter saturation (second instance with CNT_WIDTH=4).
// -----------------------------------------------------------------------------
module tb_handshake_constant_check;

    localparam logic [31:0] K = 32'h0000_0FF4;

    logic        clk;
    logic        rst;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic        outs_valid;
    logic        outs_ready;
    logic        match;
    logic [15:0] mismatch_count;
    logic        error;

    logic [31:0] ins_s;
    logic        ins_valid_s;
    logic        ins_ready_s;
    logic        outs_valid_s;
    logic        outs_ready_s;
    logic        match_s;
    logic [3:0]  mismatch_count_s;
    logic        error_s;

    int tests;
    int fails;
    int pushes;
    int pops;
    int tally;
    logic exp_q[$];

    handshake_constant_check u_dut (
        .clk            (clk),
        .rst            (rst),
        .ins            (ins),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .outs_valid     (outs_valid),
        .outs_ready     (outs_ready),
        .match          (match),
        .mismatch_count (mismatch_count),
        .error          (error)
    );

    handshake_constant_check #(.CNT_WIDTH(4)) u_sat (
        .clk            (clk),
        .rst            (rst),
        .ins            (ins_s),
        .ins_valid      (ins_valid_s),
        .ins_ready      (ins_ready_s),
        .outs_valid     (outs_valid_s),
        .outs_ready     (outs_ready_s),
        .match          (match_s),
        .mismatch_count (mismatch_count_s),
        .error          (error_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock on u_dut: score the handshakes visible before the edge, then
    // advance to 1 time unit after the edge.
    task automatic cycle();
        logic do_push;
        logic do_pop;
        do_push = ins_valid && ins_ready;
        do_pop  = outs_valid && outs_ready;
        if (do_pop) begin
            if (exp_q.size() == 0) begin
                chk("pop_when_model_empty", 32'(outs_valid), 32'd0);
            end else begin
                chk("pop_match", 32'(match), 32'(exp_q.pop_front()));
            end
            pops++;
        end
        if (do_push) begin
            exp_q.push_back(ins == K);
            if (ins != K) tally++;
            pushes++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ins_valid  = 1'b0;
        outs_ready = 1'b1;
        for (int i = 0; i < 10 && outs_valid; i++) cycle();
        chk("drain_empty", 32'(outs_valid), 32'd0);
        chk("drain_model_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int start_push;
        int start_pop;
        int guard;
        logic [31:0] v;

        tests = 0; fails = 0; pushes = 0; pops = 0; tally = 0;
        rst = 1'b0;
        ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
        ins_s = '0; ins_valid_s = 1'b0; outs_ready_s = 1'b0;

        // ---- reset state ----
        #12;
        chk("rst_ins_ready", 32'(ins_ready), 32'd1);
        chk("rst_outs_valid", 32'(outs_valid), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_mismatch_count", 32'(mismatch_count), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // ---- T1: 0xFF4, 0x123, 0xFF4 with outs_ready held ----
        outs_ready = 1'b1;
        ins_valid  = 1'b1;
        ins = K;
        chk("t1_not_valid_before_accept", 32'(outs_valid), 32'd0);
        cycle();
        chk("t1_valid0", 32'(outs_valid), 32'd1);
        chk("t1_match0", 32'(match), 32'd1);
        chk("t1_cnt0", 32'(mismatch_count), 32'd0);
        ins = 32'h123;
        cycle();
        chk("t1_valid1", 32'(outs_valid), 32'd1);
        chk("t1_match1", 32'(match), 32'd0);
        chk("t1_cnt1", 32'(mismatch_count), 32'd1);
        chk("t1_err1", 32'(error), 32'd1);
        ins = K;
        cycle();
        chk("t1_valid2", 32'(outs_valid), 32'd1);
        chk("t1_match2", 32'(match), 32'd1);
        ins_valid = 1'b0;
        cycle();
        chk("t1_empty", 32'(outs_valid), 32'd0);

        // ---- T2: back-pressure, four 0xFF4 tokens ----
        start_push = pushes;
        start_pop  = pops;
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins = K;
        cycle();
        chk("t2_ready_after_1", 32'(ins_ready), 32'd1);
        cycle();
        chk("t2_ready_after_2", 32'(ins_ready), 32'd0);
        chk("t2_valid_full", 32'(outs_valid), 32'd1);
        cycle();
        chk("t2_still_full", 32'(ins_ready), 32'd0);
        chk("t2_accepted_two", 32'(pushes - start_push), 32'd2);
        outs_ready = 1'b1;
        cycle();
        chk("t2_ready_after_pop", 32'(ins_ready), 32'd1);
        chk("t2_no_sameclk_push", 32'(pushes - start_push), 32'd2);
        guard = 0;
        while ((pushes - start_push) < 4 && guard < 20) begin
            cycle();
            guard++;
        end
        drain();
        chk("t2_pushes", 32'(pushes - start_push), 32'd4);
        chk("t2_pops", 32'(pops - start_pop), 32'd4);

        // ---- T6: steady count=1, push+pop each cycle, alternating ----
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins = K;
        cycle();
        outs_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ins = (i % 2 == 0) ? 32'h0 : K;
            cycle();
            chk("t6_valid", 32'(outs_valid), 32'd1);
            chk("t6_ready", 32'(ins_ready), 32'd1);
            chk("t6_match", 32'(match), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        drain();

        // ---- T3: random valid/ready, 1000 tokens ----
        start_push = pushes;
        guard = 0;
        ins_valid = 1'b0;
        while ((pushes - start_push) < 1000 && guard < 20000) begin
            // hold the offered token while it is stalled
            if (!(ins_valid && !ins_ready)) begin
                ins_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) begin
                    v = $urandom;
                    if (v == K) v = 32'h0;
                    ins = v;
                end else begin
                    ins = K;
                end
            end
            outs_ready = ($urandom_range(0, 2) != 0);
            cycle();
            guard++;
        end
        chk("t3_tokens", 32'(pushes - start_push), 32'd1000);
        drain();
        chk("t3_mismatch_count", 32'(mismatch_count), 32'(tally));
        chk("t3_error", 32'(error), 32'd1);

        // ---- T5: reset mid-stream at count=2 with error set ----
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins = K;
        cycle();
        ins = 32'h55;
        cycle();
        ins_valid = 1'b0;
        chk("t5_full", 32'(ins_ready), 32'd0);
        chk("t5_err_before", 32'(error), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_outs_valid", 32'(outs_valid), 32'd0);
        chk("t5_ins_ready", 32'(ins_ready), 32'd1);
        chk("t5_match", 32'(match), 32'd0);
        chk("t5_cnt", 32'(mismatch_count), 32'd0);
        chk("t5_err", 32'(error), 32'd0);
        exp_q.delete();
        tally = 0;
        #3;
        rst = 1'b1;
        outs_ready = 1'b1;
        ins_valid  = 1'b1;
        ins = K;
        chk("t5_idle_after_release", 32'(outs_valid), 32'd0);
        cycle();
        chk("t5_new_valid", 32'(outs_valid), 32'd1);
        chk("t5_new_match", 32'(match), 32'd1);
        chk("t5_new_cnt", 32'(mismatch_count), 32'd0);
        drain();

        // ---- T4: saturation on the CNT_WIDTH=4 instance ----
        chk("t4_cnt_start", 32'(mismatch_count_s), 32'd0);
        outs_ready_s = 1'b1;
        ins_valid_s  = 1'b1;
        ins_s = 32'h1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1)  chk("t4_cnt_1", 32'(mismatch_count_s), 32'd1);
            if (k == 14) chk("t4_cnt_14", 32'(mismatch_count_s), 32'd14);
            if (k == 15) chk("t4_cnt_15", 32'(mismatch_count_s), 32'hF);
            if (k == 16) chk("t4_cnt_16", 32'(mismatch_count_s), 32'hF);
        end
        chk("t4_cnt_20", 32'(mismatch_count_s), 32'hF);
        chk("t4_error", 32'(error_s), 32'd1);
        chk("t4_match", 32'(match_s), 32'd0);
        ins_valid_s = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
